// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   NOP            : all-zero instruction word inserted as an IF/ID bubble
//   OP_*           : opcodes the stall-control unit and decoder care about
//   *_HI / *_LO    : bit positions of the opcode, rs and rt fields
//   ifAction_e     : what the IF stage does on a given clock edge
//   selectAction() : strict-priority choice reset > hold > flush > advance
package mips_pkg;

   localparam logic [31:0] NOP      = 32'h0000_0000;

   localparam logic [5:0]  OP_RTYPE = 6'd0;
   localparam logic [5:0]  OP_BEQ   = 6'd4;
   localparam logic [5:0]  OP_LW    = 6'd35;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;

   typedef enum logic [1:0] {
      ACT_RESET,
      ACT_HOLD,
      ACT_FLUSH,
      ACT_ADVANCE
   } ifAction_e;

   // A stalled beq has not resolved yet, so stall outranks branch_taken.
   function automatic ifAction_e selectAction(input logic rst,
                                              input logic stall,
                                              input logic taken);
      if (rst)        return ACT_RESET;
      else if (stall) return ACT_HOLD;
      else if (taken) return ACT_FLUSH;
      else            return ACT_ADVANCE;
   endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Signal bundle between the IF/ID stage and its surroundings
// (instruction memory, branch stall control, ID-stage beq resolution, decoder).
//   master : the if_id_stage side (drives imem_addr, IF/ID fields, counters)
//   slave  : the environment side (drives stall, redirect and fetched word)
interface if_id_stage_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);

   logic                  stallSignal;
   logic                  branch_taken;
   logic [ADDR_WIDTH-1:0] branch_target;
   logic [31:0]           imem_instr;

   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           IF_ID_instr;
   logic [ADDR_WIDTH-1:0] IF_ID_pcPlus4;
   logic                  IF_ID_valid;
   logic [5:0]            opCode;
   logic [4:0]            IF_ID_rs;
   logic [4:0]            IF_ID_rt;
   logic [CNT_WIDTH-1:0]  stall_count;
   logic [CNT_WIDTH-1:0]  flush_count;

   modport master (
      input  stallSignal, branch_taken, branch_target, imem_instr,
      output imem_addr, IF_ID_instr, IF_ID_pcPlus4, IF_ID_valid,
             opCode, IF_ID_rs, IF_ID_rt, stall_count, flush_count
   );

   modport slave (
      output stallSignal, branch_taken, branch_target, imem_instr,
      input  imem_addr, IF_ID_instr, IF_ID_pcPlus4, IF_ID_valid,
             opCode, IF_ID_rs, IF_ID_rt, stall_count, flush_count
   );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears the count
//   inc   : count one event this cycle
//   count : current value
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   function automatic logic [WIDTH-1:0] satInc(input logic [WIDTH-1:0] v);
      return (&v) ? v : v + WIDTH'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (inc)
         count <= satInc(count);
   end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus the IF/ID pipeline register.
// Holds the PC, presents it as the instruction-memory address, and latches the
// fetched word with its PC+4 into IF/ID. A stall freezes PC and IF/ID; a taken
// beq redirects the PC and turns IF/ID into a NOP bubble.
//   clk, reset         : clock and synchronous active-high reset
//   bus.stallSignal    : hold PC and IF/ID this cycle
//   bus.branch_taken   : beq in ID taken; redirect to bus.branch_target
//   bus.imem_instr     : word at bus.imem_addr (combinational memory read)
//   bus.imem_addr      : current PC
//   bus.IF_ID_*        : registered instruction, its PC+4, valid flag
//   bus.opCode/rs/rt   : field slices of IF_ID_instr
//   bus.stall_count    : saturating count of stalled cycles
//   bus.flush_count    : saturating count of redirect cycles
module if_id_stage #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic          clk,
   input  logic          reset,
   if_id_stage_if.master bus
);

   import mips_pkg::*;

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pcPlus4;
   logic [31:0]           ifIdInstr;
   logic [ADDR_WIDTH-1:0] ifIdPcPlus4;
   logic                  ifIdValid;
   logic [CNT_WIDTH-1:0]  stallCount;
   logic [CNT_WIDTH-1:0]  flushCount;
   ifAction_e             action;

   always_comb begin
      action = selectAction(reset, bus.stallSignal, bus.branch_taken);
   end

   // Natural modulo-2^ADDR_WIDTH wrap at the top of the address space.
   assign pcPlus4 = pc + ADDR_WIDTH'(4);

   always_ff @(posedge clk) begin
      case (action)
         ACT_RESET: begin
            pc          <= RESET_PC;
            ifIdInstr   <= NOP;
            ifIdPcPlus4 <= '0;
            ifIdValid   <= 1'b0;
         end
         ACT_HOLD: begin
            pc          <= pc;
            ifIdInstr   <= ifIdInstr;
            ifIdPcPlus4 <= ifIdPcPlus4;
            ifIdValid   <= ifIdValid;
         end
         ACT_FLUSH: begin
            // Misaligned targets are silently word-aligned.
            pc          <= bus.branch_target & ~ADDR_WIDTH'(3);
            ifIdInstr   <= NOP;
            ifIdPcPlus4 <= '0;
            ifIdValid   <= 1'b0;
         end
         default: begin
            pc          <= pcPlus4;
            ifIdInstr   <= bus.imem_instr;
            ifIdPcPlus4 <= pcPlus4;
            ifIdValid   <= 1'b1;
         end
      endcase
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) stallCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (action == ACT_HOLD),
      .count (stallCount)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) flushCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (action == ACT_FLUSH),
      .count (flushCount)
   );

   assign bus.imem_addr     = pc;
   assign bus.IF_ID_instr   = ifIdInstr;
   assign bus.IF_ID_pcPlus4 = ifIdPcPlus4;
   assign bus.IF_ID_valid   = ifIdValid;
   assign bus.opCode        = ifIdInstr[OPC_HI:OPC_LO];
   assign bus.IF_ID_rs      = ifIdInstr[RS_HI:RS_LO];
   assign bus.IF_ID_rt      = ifIdInstr[RT_HI:RT_LO];
   assign bus.stall_count   = stallCount;
   assign bus.flush_count   = flushCount;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: hand-written vector table, saturation sequence and a
// randomized run compared against a behavioural model of the fetch stage.
module tb_if_id_stage;

   localparam int          AW    = 32;
   localparam int          CW    = 4;
   localparam int          CMAX  = (1 << CW) - 1;
   localparam logic [31:0] RPC   = 32'h0;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   if_id_stage_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   if_id_stage #(.ADDR_WIDTH(AW), .RESET_PC(RPC), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // Instruction memory: fixed lw at 0x8, address-derived words elsewhere.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h8) return 32'h8C22_0004;
      return {a[15:0] ^ 16'hBEEF, a[31:16] ^ a[15:0]};
   endfunction

   assign bus.imem_instr = memWord(bus.imem_addr);

   int compared   = 0;
   int mismatched = 0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: state of the fetch stage as the rules describe it.
   logic [31:0] mPc, mInstr, mPc4;
   logic        mValid;
   int          mStall, mFlush;

   task automatic modelEdge(input bit r, input bit s, input bit t, input logic [31:0] tg);
      if (r) begin
         mPc = RPC; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
         mStall = 0; mFlush = 0;
      end else if (s) begin
         if (mStall < CMAX) mStall++;
      end else if (t) begin
         mPc = tg - (tg % 32'd4);
         mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
         if (mFlush < CMAX) mFlush++;
      end else begin
         mInstr = memWord(mPc);
         mPc    = 32'((64'(mPc) + 64'd4) % 64'h1_0000_0000);
         mPc4   = mPc;
         mValid = 1'b1;
      end
   endtask

   // Apply inputs, advance one edge, sample 1 time unit later.
   task automatic step(input bit r, input bit s, input bit t, input logic [31:0] tg);
      reset             = r;
      bus.stallSignal   = s;
      bus.branch_taken  = t;
      bus.branch_target = tg;
      modelEdge(r, s, t, tg);
      @(posedge clk);
      #1;
   endtask

   task automatic checkModel(input string tag);
      cmp({tag, ".addr"},  64'(bus.imem_addr),     64'(mPc));
      cmp({tag, ".instr"}, 64'(bus.IF_ID_instr),   64'(mInstr));
      cmp({tag, ".pc4"},   64'(bus.IF_ID_pcPlus4), 64'(mPc4));
      cmp({tag, ".valid"}, 64'(bus.IF_ID_valid),   64'(mValid));
      cmp({tag, ".op"},    64'(bus.opCode),        64'(mInstr >> 26));
      cmp({tag, ".rs"},    64'(bus.IF_ID_rs),      64'((mInstr >> 21) % 32));
      cmp({tag, ".rt"},    64'(bus.IF_ID_rt),      64'((mInstr >> 16) % 32));
      cmp({tag, ".stall"}, 64'(bus.stall_count),   64'(mStall));
      cmp({tag, ".flush"}, 64'(bus.flush_count),   64'(mFlush));
   endtask

   typedef struct {
      bit          rst, stall, taken;
      logic [31:0] target;
      logic [31:0] expAddr, expInstr, expPc4;
      bit          expValid;
      int          expStall, expFlush;
   } vec_t;

   vec_t vecs[16];

   initial begin
      bus.stallSignal   = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'h0;
      mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
      mStall = 0; mFlush = 0;

      vecs[0]  = '{0,0,0, 32'h0,        32'h4,        memWord(32'h0),        32'h4,  1, 0, 0};
      vecs[1]  = '{0,0,0, 32'h0,        32'h8,        memWord(32'h4),        32'h8,  1, 0, 0};
      vecs[2]  = '{0,0,0, 32'h0,        32'hC,        32'h8C22_0004,         32'hC,  1, 0, 0};
      vecs[3]  = '{0,0,0, 32'h0,        32'h10,       memWord(32'hC),        32'h10, 1, 0, 0};
      vecs[4]  = '{0,1,0, 32'h0,        32'h10,       memWord(32'hC),        32'h10, 1, 1, 0};
      vecs[5]  = '{0,1,0, 32'h0,        32'h10,       memWord(32'hC),        32'h10, 1, 2, 0};
      vecs[6]  = '{0,1,0, 32'h0,        32'h10,       memWord(32'hC),        32'h10, 1, 3, 0};
      vecs[7]  = '{0,0,0, 32'h0,        32'h14,       memWord(32'h10),       32'h14, 1, 3, 0};
      vecs[8]  = '{0,0,1, 32'h40,       32'h40,       32'h0,                 32'h0,  0, 3, 1};
      vecs[9]  = '{0,0,0, 32'h0,        32'h44,       memWord(32'h40),       32'h44, 1, 3, 1};
      vecs[10] = '{0,1,1, 32'h80,       32'h44,       memWord(32'h40),       32'h44, 1, 4, 1};
      vecs[11] = '{0,0,1, 32'h43,       32'h40,       32'h0,                 32'h0,  0, 4, 2};
      vecs[12] = '{0,0,1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,               32'h0,  0, 4, 3};
      vecs[13] = '{0,0,0, 32'h0,        32'h0,        memWord(32'hFFFF_FFFC), 32'h0, 1, 4, 3};
      vecs[14] = '{1,0,1, 32'h80,       32'h0,        32'h0,                 32'h0,  0, 0, 0};
      vecs[15] = '{0,0,0, 32'h0,        32'h4,        memWord(32'h0),        32'h4,  1, 0, 0};

      // Two cycles of reset.
      step(1, 0, 0, 32'h0);
      step(1, 0, 0, 32'h0);
      cmp("rst.addr",  64'(bus.imem_addr),   64'h0);
      cmp("rst.instr", 64'(bus.IF_ID_instr), 64'h0);
      cmp("rst.valid", 64'(bus.IF_ID_valid), 64'h0);
      cmp("rst.stall", 64'(bus.stall_count), 64'h0);
      cmp("rst.flush", 64'(bus.flush_count), 64'h0);

      for (int i = 0; i < 16; i++) begin
         step(vecs[i].rst, vecs[i].stall, vecs[i].taken, vecs[i].target);
         cmp($sformatf("vec%0d.addr", i),  64'(bus.imem_addr),     64'(vecs[i].expAddr));
         cmp($sformatf("vec%0d.instr", i), 64'(bus.IF_ID_instr),   64'(vecs[i].expInstr));
         cmp($sformatf("vec%0d.pc4", i),   64'(bus.IF_ID_pcPlus4), 64'(vecs[i].expPc4));
         cmp($sformatf("vec%0d.valid", i), 64'(bus.IF_ID_valid),   64'(vecs[i].expValid));
         cmp($sformatf("vec%0d.op", i),    64'(bus.opCode),        64'(vecs[i].expInstr[31:26]));
         cmp($sformatf("vec%0d.stall", i), 64'(bus.stall_count),   64'(vecs[i].expStall));
         cmp($sformatf("vec%0d.flush", i), 64'(bus.flush_count),   64'(vecs[i].expFlush));
         if (i == 2) begin
            cmp("lw.opCode", 64'(bus.opCode),   64'd35);
            cmp("lw.rs",     64'(bus.IF_ID_rs), 64'd1);
            cmp("lw.rt",     64'(bus.IF_ID_rt), 64'd2);
         end
      end

      // Stall counter saturation: 15 cycles reach all-ones, more must not wrap.
      step(1, 0, 0, 32'h0);
      for (int i = 0; i < CMAX; i++) step(0, 1, 0, 32'h0);
      cmp("sat.stall15", 64'(bus.stall_count), 64'd15);
      step(0, 1, 0, 32'h0);
      step(0, 1, 1, 32'h80);
      cmp("sat.stallHeld", 64'(bus.stall_count), 64'd15);
      cmp("sat.addr",      64'(bus.imem_addr),   64'h0);
      cmp("sat.flush",     64'(bus.flush_count), 64'h0);
      step(0, 0, 0, 32'h0);
      cmp("sat.release.pc4", 64'(bus.IF_ID_pcPlus4), 64'h4);

      // Randomized run against the behavioural model.
      step(1, 0, 0, 32'h0);
      checkModel("rnd.start");
      for (int n = 0; n < 600; n++) begin
         bit          r, s, t;
         logic [31:0] tg;
         r  = ($urandom_range(0, 99) < 2);
         s  = ($urandom_range(0, 99) < 30);
         t  = ($urandom_range(0, 99) < 20);
         tg = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom_range(0, 1023));
         step(r, s, t, tg);
         checkModel($sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
